// File: rtl/ds_rx_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : ds_rx_word_aligner
// Brief    : Serial-to-parallel deserialiser with bit-slip word alignment on a
//            repeated training word; emits aligned words once locked.
// Revision : 1.0 - initial release
// ============================================================================
module ds_rx_word_aligner #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'h5C,
    parameter int               LOCK_COUNT    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_ser_in,
    input  logic                     i_en,
    input  logic                     i_align_req,
    output logic [WIDTH-1:0]         o_data_out,
    output logic                     o_data_valid,
    output logic                     o_locked,
    output logic [$clog2(WIDTH)-1:0] o_bitslip_cnt,
    output logic                     o_align_err
);

    localparam int CW = $clog2(WIDTH);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int AW = $clog2(2 * WIDTH + 1);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [MW-1:0]    r_match_cnt;
    logic [MW-1:0]    w_match_cnt_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_slip_pend;
    logic [AW-1:0]    r_attempts;
    logic             r_align_err;
    logic [CW-1:0]    r_bitslip_cnt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             w_boundary;
    logic             w_match;
    logic             w_slip;
    logic             w_emit;

    always_comb begin
        w_shreg_nxt = {r_shreg[WIDTH-2:0], i_ser_in};
        // The cycle consuming a pending slip holds bit_cnt at 0, so it can never be a boundary.
        w_boundary  = i_en && !r_slip_pend && (r_bit_cnt == CW'(WIDTH - 1));
        w_match     = (w_shreg_nxt == TRAIN_PATTERN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SEARCH;
            r_match_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_cnt_nxt;
        end
    end

    // Next-state logic; align_req wins over any same-cycle boundary decision
    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_slip          = 1'b0;
        w_emit          = 1'b0;
        if (i_align_req) begin
            w_state_nxt     = S_SEARCH;
            w_match_cnt_nxt = '0;
        end else if (w_boundary) begin
            case (r_state)
                S_SEARCH: begin
                    if (w_match) begin
                        w_match_cnt_nxt = MW'(1);
                        w_state_nxt     = (LOCK_COUNT == 1) ? S_LOCKED : S_CONFIRM;
                    end else begin
                        w_slip = 1'b1;
                    end
                end
                S_CONFIRM: begin
                    if (w_match) begin
                        w_match_cnt_nxt = r_match_cnt + 1'b1;
                        if (r_match_cnt == MW'(LOCK_COUNT - 1)) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        w_state_nxt     = S_SEARCH;
                        w_match_cnt_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    w_emit = 1'b1;
                end
                default: begin
                    w_state_nxt     = S_SEARCH;
                    w_match_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        o_locked      = (r_state == S_LOCKED);
        o_data_out    = r_data_out;
        o_data_valid  = r_data_valid;
        o_bitslip_cnt = r_bitslip_cnt;
        o_align_err   = r_align_err;
    end

    // Datapath: shifter, boundary counter, slip bookkeeping and output word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_slip_pend   <= 1'b0;
            r_attempts    <= '0;
            r_align_err   <= 1'b0;
            r_bitslip_cnt <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
        end else begin
            if (i_en) begin
                r_shreg <= w_shreg_nxt;
                if (r_slip_pend) begin
                    r_slip_pend <= 1'b0;
                end else if (r_bit_cnt == CW'(WIDTH - 1)) begin
                    r_bit_cnt <= '0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
            if (w_slip) begin
                r_slip_pend   <= 1'b1;
                r_bitslip_cnt <= r_bitslip_cnt + 1'b1;
                if (r_attempts != AW'(2 * WIDTH)) begin
                    r_attempts <= r_attempts + 1'b1;
                end
                if (r_attempts == AW'(2 * WIDTH - 1)) begin
                    r_align_err <= 1'b1;
                end
            end
            if (i_align_req) begin
                r_attempts  <= '0;
                r_align_err <= 1'b0;
            end
            r_data_valid <= w_emit;
            if (w_emit) begin
                r_data_out <= w_shreg_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ds_rx_word_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds_rx_word_aligner
// Brief    : Randomised scoreboard bench for ds_rx_word_aligner against a
//            bit-index reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ds_rx_word_aligner;

    localparam int         W   = 8;
    localparam logic [7:0] PAT = 8'h5C;
    localparam int         LC  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_in = 1'b0;
    logic       en = 1'b0;
    logic       align_req = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic [2:0] bitslip_cnt;
    logic       align_err;

    ds_rx_word_aligner #(.WIDTH(W), .TRAIN_PATTERN(PAT), .LOCK_COUNT(LC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_ser_in     (ser_in),
        .i_en         (en),
        .i_align_req  (align_req),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .o_locked     (locked),
        .o_bitslip_cnt(bitslip_cnt),
        .o_align_err  (align_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lk;
        logic [2:0] sl;
        logic       er;
        logic       v;
        logic [7:0] d;
    } exp_t;

    exp_t       sq[$];
    logic [7:0] dq[$];
    int         total = 0;
    int         bad   = 0;

    // Reference model: boundaries are positions in the stream of enabled bits
    int         nbits, next_bnd, mcnt, attempts, slips;
    bit         mlocked, merr;
    logic [7:0] mword, mdata;
    logic [7:0] pat_v = PAT;
    int         pp;

    task automatic model_reset();
        nbits = 0; next_bnd = W - 1; mcnt = 0; attempts = 0; slips = 0;
        mlocked = 0; merr = 0; mword = 8'h00; mdata = 8'h00;
    endtask

    task automatic step(input logic r, input logic e, input logic s, input logic a);
        exp_t x;
        bit   bnd;
        bit   v;
        logic [7:0] wn;
        @(posedge clk);
        #2;
        rst = r; en = e; ser_in = s; align_req = a;
        v = 0;
        if (r) begin
            model_reset();
        end else begin
            wn  = mword;
            bnd = 0;
            if (e) begin
                wn  = {mword[6:0], s};
                bnd = (nbits == next_bnd);
                nbits++;
            end
            if (bnd) next_bnd += W;
            if (a) begin
                mlocked = 0; mcnt = 0; attempts = 0; merr = 0;
            end else if (bnd) begin
                if (mlocked) begin
                    v = 1; mdata = wn; dq.push_back(wn);
                end else if (wn == PAT) begin
                    mcnt++;
                    if (mcnt == LC) mlocked = 1;
                end else if (mcnt > 0) begin
                    mcnt = 0;
                end else begin
                    slips = (slips + 1) % W;
                    next_bnd += 1;
                    if (attempts < 2 * W) begin
                        attempts++;
                        if (attempts == 2 * W) merr = 1;
                    end
                end
            end
            mword = wn;
        end
        x.lk = mlocked; x.sl = 3'(slips); x.er = merr; x.v = v; x.d = mdata;
        sq.push_back(x);
    endtask

    function automatic logic patbit(input int p);
        return pat_v[W - 1 - (p % W)];
    endfunction

    // mode 0: training stream, 1: zeros; en_drop/err in percent, areq per mille
    task automatic send(input int n, input int mode, input int en_drop,
                        input int err, input int areq);
        logic e, s, a;
        for (int i = 0; i < n; i++) begin
            e = ($urandom_range(99) >= en_drop);
            a = ($urandom_range(999) < areq);
            if (!e) s = 1'($urandom);
            else if (mode == 1) s = 1'b0;
            else begin
                s = patbit(pp);
                pp++;
                if ($urandom_range(99) < err) s = ~s;
            end
            step(1'b0, e, s, a);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'(i), 1'b0);
    endtask

    // Monitor: compares status every cycle and pops a data word on each valid pulse
    initial begin
        exp_t       x;
        logic [7:0] d;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                x = sq.pop_front();
                total++;
                if (locked !== x.lk || bitslip_cnt !== x.sl || align_err !== x.er ||
                    data_valid !== x.v || data_out !== x.d) begin
                    bad++;
                    $display("FAIL status t=%0t got lk=%b sl=%0d er=%b v=%b d=%h expected lk=%b sl=%0d er=%b v=%b d=%h",
                             $time, locked, bitslip_cnt, align_err, data_valid, data_out,
                             x.lk, x.sl, x.er, x.v, x.d);
                end
                if (data_valid === 1'b1) begin
                    total++;
                    if (dq.size() == 0) begin
                        bad++;
                        $display("FAIL word t=%0t got unexpected valid data=%h expected none",
                                 $time, data_out);
                    end else begin
                        d = dq.pop_front();
                        if (data_out !== d) begin
                            bad++;
                            $display("FAIL word t=%0t got %h expected %h", $time, data_out, d);
                        end
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        pp = 0;
        do_reset(3);
        send(64, 0, 0, 0, 0);

        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0);
        pp = 0;
        send(80, 0, 0, 0, 0);

        do_reset(1);
        pp = 0;
        send(16, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, ~patbit(pp), 1'b0);
            pp++;
        end
        send(48, 0, 0, 0, 0);

        do_reset(1);
        send(170, 1, 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        send(10, 1, 0, 0, 0);

        do_reset(1);
        pp = 0;
        send(44, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'($urandom), 1'b0);
        send(20, 0, 0, 0, 0);
        do_reset(1);
        pp = 0;
        send(50, 0, 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            do_reset(1);
            for (int i = 0; i < int'($urandom_range(7)); i++)
                step(1'b0, 1'b1, 1'($urandom), 1'b0);
            pp = 0;
            send(200, 0, 10, 1, 3);
        end

        @(posedge clk);
        #3;
        total++;
        if (sq.size() != 0 || dq.size() != 0) begin
            bad++;
            $display("FAIL drain got status=%0d words=%0d left expected 0 0", sq.size(), dq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
